// File: rtl/rr_mux_arbiter_8_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// State encoding, requester count and select width live here.
package rr_mux_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Expand a binary select into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] sel_to_onehot(
        input logic [SEL_W-1:0] sel
    );
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_8_next_sel.sv
// Combinational round-robin winner search.
// Rotates the request vector so ptr lands at bit 0, then priority-encodes.
module rr_next_sel
    import rr_mux_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // Lowest set bit of the rotated vector is the nearest request at or after ptr.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        off   = '0;
        found = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        idx = off + ptr;
    end

endmodule

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter owning the 8-to-1 bit-select path, with bounded bursts.
// Optional ARB_LOCK_EN adds lock_in to suppress hold-count release.
module rr_mux_arbiter_8
    import rr_mux_arbiter_8_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ARB_LOCK_EN
    input  logic             lock_in,
`endif
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] d_in,
    output logic [N_REQ-1:0] grant_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             y_out,
    output logic             valid_out,
    output logic             busy_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             valid_q, valid_d;

    logic             found;
    logic [SEL_W-1:0] win_idx;
    logic             hold_done;
    logic             req_drop;
    logic             load;

    rr_next_sel u_next_sel (
        .req   (req_in),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win_idx)
    );

    // Arbitration: pick, hold, release and re-grant without an idle bubble.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        hold_done = (cnt_q == CNT_MAX);
`ifdef ARB_LOCK_EN
        hold_done = hold_done && !lock_in;
`endif
        req_drop  = !req_in[sel_q];

        unique case (state_q)
            IDLE: begin
                load = found;
            end
            GRANT: begin
                if (hold_done || req_drop) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (load) begin
            state_d = GRANT;
            grant_d = sel_to_onehot(win_idx);
            sel_d   = win_idx;
            ptr_d   = win_idx + 1'b1;
            cnt_d   = '0;
        end
    end

    // Datapath: sample the selected bit while busy, zero otherwise.
    always_comb begin
        valid_d = (state_q == GRANT);
        y_d     = valid_d ? d_in[sel_q] : 1'b0;
    end

    // Arbiter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign grant_out = grant_q;
    assign sel_out   = sel_q;
    assign y_out     = y_q;
    assign valid_out = valid_q;
    assign busy_out  = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Randomized and directed bench for rr_mux_arbiter_8.
// Three instances (hold 4, 1, 2) share stimulus; a queue-free integer model predicts each.
module tb_rr_mux_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic [7:0] d_in = '0;
    bit         lock_v = 1'b0;

    logic [7:0] g [3];
    logic [2:0] s [3];
    logic       y [3];
    logic       v [3];
    logic       b [3];

    int n_tests = 0;
    int n_fail  = 0;

    int hold_c [3] = '{4, 1, 2};

    bit         m_busy  [3];
    int         m_sel   [3];
    int         m_ptr   [3];
    int         m_cnt   [3];
    bit         m_y     [3];
    bit         m_valid [3];

    always #5 clk = ~clk;

    rr_mux_arbiter_8 #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
        .lock_in(lock_v),
`endif
        .req_in(req_in), .d_in(d_in),
        .grant_out(g[0]), .sel_out(s[0]), .y_out(y[0]),
        .valid_out(v[0]), .busy_out(b[0])
    );

    rr_mux_arbiter_8 #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
        .lock_in(lock_v),
`endif
        .req_in(req_in), .d_in(d_in),
        .grant_out(g[1]), .sel_out(s[1]), .y_out(y[1]),
        .valid_out(v[1]), .busy_out(b[1])
    );

    rr_mux_arbiter_8 #(.HOLD_CYCLES(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
        .lock_in(lock_v),
`endif
        .req_in(req_in), .d_in(d_in),
        .grant_out(g[2]), .sel_out(s[2]), .y_out(y[2]),
        .valid_out(v[2]), .busy_out(b[2])
    );

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k]  = 0;
            m_sel[k]   = 0;
            m_ptr[k]   = 0;
            m_cnt[k]   = 0;
            m_y[k]     = 0;
            m_valid[k] = 0;
        end
    endtask

    // One clock edge of the arbitration rules, written as plain integer arithmetic.
    task automatic model_edge(int k, logic [7:0] r, logic [7:0] d, bit lk);
        int  w;
        bit  rel;
        m_y[k]     = m_busy[k] ? d[m_sel[k]] : 1'b0;
        m_valid[k] = m_busy[k];
        rel = !m_busy[k] || !r[m_sel[k]] ||
              (m_cnt[k] >= hold_c[k] - 1 && !lk);
        if (!rel) begin
            if (m_cnt[k] < hold_c[k] - 1) m_cnt[k] = m_cnt[k] + 1;
        end else begin
            w = -1;
            for (int j = 0; j < 8; j++) begin
                if (w < 0 && r[(m_ptr[k] + j) % 8]) w = (m_ptr[k] + j) % 8;
            end
            if (w >= 0) begin
                m_busy[k] = 1;
                m_sel[k]  = w;
                m_ptr[k]  = (w + 1) % 8;
                m_cnt[k]  = 0;
            end else begin
                m_busy[k] = 0;
            end
        end
    endtask

    function automatic logic [13:0] exp_vec(int k);
        logic [7:0] eg;
        eg = m_busy[k] ? (8'h01 << m_sel[k]) : 8'h00;
        return {eg, 3'(m_sel[k]), m_y[k], m_valid[k], m_busy[k]};
    endfunction

    // Advance one edge: capture inputs, clock DUTs and model, settle.
    task automatic tick();
        logic [7:0] r;
        logic [7:0] d;
        bit         lk;
        r  = req_in;
        d  = d_in;
        lk = lock_v;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k, r, d, lk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_in = '0;
        d_in   = '0;
        lock_v = 1'b0;
        model_reset();
        #4;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({g[k], s[k], y[k], v[k], b[k]} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_init k=%0d got %h exp 0",
                         k, {g[k], s[k], y[k], v[k], b[k]});
            end
        end
        #5;
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++;
            if ({g[0], s[0], y[0], v[0], b[0]} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d got %h exp %h",
                         t, {g[0], s[0], y[0], v[0], b[0]}, exp_vec(0));
            end
        end
    endtask

    task automatic test_reset_mid();
        req_in = 8'hFF;
        d_in   = 8'hA5;
        for (int t = 0; t < 3; t++) tick();
        n_tests++;
        if (b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy got %b exp 1", b[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({g[k], s[k], y[k], v[k], b[k]} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_async k=%0d got %h exp 0",
                         k, {g[k], s[k], y[k], v[k], b[k]});
            end
        end
        model_reset();
        #2;
        rst    = 1'b0;
        req_in = 8'h00;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++;
            if ({g[0], s[0], y[0], v[0], b[0]} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_stay_idle t=%0d got %h exp 0",
                         t, {g[0], s[0], y[0], v[0], b[0]});
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_in = 8'h08;
        d_in   = 8'h08;
        tick();
        n_tests++;
        if ({g[0], s[0], v[0]} !== {8'h08, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL single_first got g=%h s=%0d v=%b exp g=08 s=3 v=0",
                     g[0], s[0], v[0]);
        end
        for (int t = 0; t < 12; t++) begin
            tick();
            n_tests++;
            if ({g[0], s[0], y[0], v[0], b[0]} !== {8'h08, 3'd3, 3'b111} ||
                {g[0], s[0], y[0], v[0], b[0]} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL single_hold t=%0d got %h exp %h",
                         t, {g[0], s[0], y[0], v[0], b[0]}, exp_vec(0));
            end
        end
    endtask

    task automatic test_rotation();
        int es0;
        int es1;
        do_reset();
        req_in = 8'h81;
        d_in   = 8'h80;
        for (int t = 0; t < 16; t++) begin
            tick();
            es0 = ((t / 4) % 2) ? 7 : 0;
            es1 = (t % 2) ? 7 : 0;
            n_tests++;
            if (s[0] !== 3'(es0) || s[1] !== 3'(es1) ||
                {g[0], s[0], y[0], v[0], b[0]} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL rotation t=%0d got s0=%0d s1=%0d exp s0=%0d s1=%0d",
                         t, s[0], s[1], es0, es1);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_in = 8'h80;
        tick();
        req_in = 8'h06;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_tests++;
            if (s[0] !== ((t < 4) ? 3'd1 : 3'd2) ||
                {g[0], s[0], y[0], v[0], b[0]} !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL wrap t=%0d got s=%0d exp s=%0d",
                         t, s[0], (t < 4) ? 1 : 2);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_in = 8'h04;
        tick();
        req_in = 8'h20;
        tick();
        n_tests++;
        if (s[0] !== 3'd5 || g[0] !== 8'h20) begin
            n_fail++;
            $display("FAIL early_move got s=%0d g=%h exp s=5 g=20", s[0], g[0]);
        end
        req_in = 8'h24;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_tests++;
            if (s[0] !== ((t < 3) ? 3'd5 : 3'd2)) begin
                n_fail++;
                $display("FAIL early_cnt_restart t=%0d got s=%0d exp %0d",
                         t, s[0], (t < 3) ? 5 : 2);
            end
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock_v = 1'b1;
        req_in = 8'h03;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_tests++;
            if (s[2] !== 3'd0 || b[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold t=%0d got s=%0d exp 0", t, s[2]);
            end
        end
        lock_v = 1'b0;
        tick();
        n_tests++;
        if (s[2] !== 3'd1 ||
            {g[2], s[2], y[2], v[2], b[2]} !== exp_vec(2)) begin
            n_fail++;
            $display("FAIL lock_release got s=%0d exp 1", s[2]);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            req_in = r;
            d_in   = 8'($urandom);
`ifdef ARB_LOCK_EN
            lock_v = ($urandom_range(0, 3) == 0);
`endif
            tick();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if ({g[k], s[k], y[k], v[k], b[k]} !== exp_vec(k) ||
                    !$onehot0(g[k])) begin
                    n_fail++;
                    $display("FAIL random t=%0d k=%0d got %h exp %h",
                             t, k, {g[k], s[k], y[k], v[k], b[k]}, exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_rotation();
        test_wrap();
        test_early_release();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
